// File: rtl/ram_arbiter.sv
// ram_arbiter
// -----------
// Two-port request arbiter and access sequencer in front of the external SRAM
// interface stage. Port A (CPU) issues reads and writes, port B (video fetch)
// issues reads only. One request is granted at a time. Each access runs
// IDLE -> ACCESS -> DONE, so peak throughput is one access every 3 cycles.
//
// Port B has priority. A streak counter bounds how many consecutive B grants
// may be made while A is waiting, so A always makes forward progress.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request (held until a_ack)
//   a_ack, a_rdata      port A completion pulse and read data
//   b_req/b_addr        port B read request (held until b_ack)
//   b_ack, b_rdata      port B completion pulse and read data
//   ram_address, ram_dataIn, ram_write  drive the SRAM stage
//   ram_dataOut         read data returned by the SRAM stage
module ram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_dataIn,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dataOut
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Port id encoding held in the access latch.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t              state_q,     state_d;
  logic [3:0]          streak_q,    streak_d;
  logic                port_q,      port_d;
  logic                we_q,        we_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic                ram_write_q, ram_write_d;
  logic                a_ack_q,     a_ack_d;
  logic                b_ack_q,     b_ack_d;
  logic [DATA_W-1:0]   a_rdata_q,   a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q,   b_rdata_d;
  logic                grant_a_s;
  logic                grant_b_s;

  // Arbitration decision; only meaningful in IDLE. B wins unless A is
  // waiting and B has already used up its allowed streak.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (state_q == ST_IDLE) begin
      if (b_req && !(a_req && (streak_q == LIMIT))) begin
        grant_b_s = 1'b1;
      end else if (a_req) begin
        grant_a_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Next-state, access latch, streak and registered output computation.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    port_d      = port_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ram_write_d = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_b_s) begin
          state_d = ST_ACCESS;
          port_d  = PORT_B;
          we_d    = 1'b0;
          addr_d  = b_addr;
          // B has no write data; the data bus keeps its last value.
          if (a_req) begin
            if (streak_q >= LIMIT) begin
              streak_d = LIMIT;
            end else begin
              streak_d = streak_q + 4'd1;
            end
          end else begin
            streak_d = 4'd0;
          end
        end else if (grant_a_s) begin
          state_d     = ST_ACCESS;
          port_d      = PORT_A;
          we_d        = a_we;
          addr_d      = a_addr;
          wdata_d     = a_wdata;
          ram_write_d = a_we;
          streak_d    = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        // Read data is captured at the edge that ends the access cycle.
        state_d = ST_DONE;
        if (port_q == PORT_A) begin
          a_ack_d = 1'b1;
          if (!we_q) begin
            a_rdata_d = ram_dataOut;
          end else begin
            a_rdata_d = a_rdata_q;
          end
        end else begin
          b_ack_d   = 1'b1;
          b_rdata_d = ram_dataOut;
        end
      end

      ST_DONE: begin
        // Bus turnaround: no arbitration in this cycle.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears ram_write asynchronously so an
  // interrupted write is aborted immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      streak_q    <= 4'd0;
      port_q      <= PORT_A;
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      ram_write_q <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= {DATA_W{1'b0}};
      b_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      port_q      <= port_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ram_write_q <= ram_write_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  // The SRAM-side outputs come only from the access latch.
  assign ram_address = addr_q;
  assign ram_dataIn  = wdata_q;
  assign ram_write   = ram_write_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a simple SRAM model that writes
// on the low phase of the access cycle and reads combinationally.
module tb_ram_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        a_req;
  logic        a_we;
  logic [15:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        b_req;
  logic [15:0] b_addr;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic [15:0] ram_address;
  logic [15:0] ram_dataIn;
  logic        ram_write;
  logic [15:0] ram_dataOut;

  int tot;
  int bad;

  logic [15:0] mem [0:65535];

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(3)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_ack       (a_ack),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_addr      (b_addr),
    .b_ack       (b_ack),
    .b_rdata     (b_rdata),
    .ram_address (ram_address),
    .ram_dataIn  (ram_dataIn),
    .ram_write   (ram_write),
    .ram_dataOut (ram_dataOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: write pulse in the low phase, asynchronous read.
  always @(negedge CLK) begin
    if (ram_write === 1'b1) mem[ram_address] = ram_dataIn;
  end
  assign ram_dataOut = mem[ram_address];

  // Drives one port A access from IDLE and reports what was observed.
  // Ends one cycle after the ack, with the DUT back in IDLE.
  task automatic a_access(input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, output int lat,
                          output int wr_cnt, output logic [15:0] rd,
                          output logic [15:0] acc_addr,
                          output logic [15:0] acc_din, output int b_hits);
    int cyc;
    cyc = 0; lat = -1; wr_cnt = 0; b_hits = 0;
    rd = 16'h0000; acc_addr = 16'h0000; acc_din = 16'h0000;
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      cyc++;
      if (ram_write === 1'b1) wr_cnt++;
      if (b_ack === 1'b1) b_hits++;
      if (cyc == 1) begin
        acc_addr = ram_address;
        acc_din  = ram_dataIn;
      end
      if (a_ack === 1'b1) begin
        lat = cyc;
        rd  = a_rdata;
        break;
      end
    end
    a_req = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0000; a_wdata = 16'h0000;
    b_req = 1'b0; b_addr = 16'h0000;
    #2 RST_N = 1'b0;
    #2;
    tot++; if (ram_write !== 1'b0) begin bad++; $display("FAIL reset_ram_write: got %b want 0", ram_write); end
    tot++; if ({a_ack, b_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks: got %b want 00", {a_ack, b_ack}); end
    tot++; if (ram_address !== 16'h0000) begin bad++; $display("FAIL reset_ram_address: got %h want 0000", ram_address); end
    tot++; if (ram_dataIn !== 16'h0000) begin bad++; $display("FAIL reset_ram_dataIn: got %h want 0000", ram_dataIn); end
    tot++; if ({a_rdata, b_rdata} !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 00000000", {a_rdata, b_rdata}); end
    @(posedge CLK); @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_write_read();
    int lat, wr, bh;
    logic [15:0] rd, aa, ad;
    a_access(1'b1, 16'h1234, 16'hBEEF, lat, wr, rd, aa, ad, bh);
    tot++; if (lat != 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
    tot++; if (wr != 1) begin bad++; $display("FAIL wr_pulse_cycles: got %0d want 1", wr); end
    tot++; if (aa !== 16'h1234) begin bad++; $display("FAIL wr_ram_address: got %h want 1234", aa); end
    tot++; if (ad !== 16'hBEEF) begin bad++; $display("FAIL wr_ram_dataIn: got %h want beef", ad); end
    tot++; if (a_ack !== 1'b0) begin bad++; $display("FAIL ack_one_cycle: got %b want 0", a_ack); end
    tot++; if (a_rdata !== 16'h0000) begin bad++; $display("FAIL wr_no_rdata_update: got %h want 0000", a_rdata); end
    tot++; if (mem[16'h1234] !== 16'hBEEF) begin bad++; $display("FAIL wr_sram_content: got %h want beef", mem[16'h1234]); end
    a_access(1'b0, 16'h1234, 16'h0000, lat, wr, rd, aa, ad, bh);
    tot++; if (lat != 2) begin bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
    tot++; if (wr != 0) begin bad++; $display("FAIL rd_no_write: got %0d want 0", wr); end
    tot++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h want beef", rd); end
    tot++; if (bh != 0) begin bad++; $display("FAIL rd_no_b_ack: got %0d want 0", bh); end
    tot++; if (a_rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_data_held: got %h want beef", a_rdata); end
  endtask

  task automatic test_addr_latch();
    int lat, wr, bh;
    logic [15:0] rd, aa, ad;
    a_access(1'b1, 16'h0010, 16'hAAAA, lat, wr, rd, aa, ad, bh);
    a_access(1'b1, 16'h0020, 16'h5555, lat, wr, rd, aa, ad, bh);
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
    @(posedge CLK); #1;
    tot++; if (ram_address !== 16'h0010) begin bad++; $display("FAIL latch_addr_access: got %h want 0010", ram_address); end
    a_addr = 16'h0020;
    #3;
    tot++; if (ram_address !== 16'h0010) begin bad++; $display("FAIL latch_addr_after_change: got %h want 0010", ram_address); end
    @(posedge CLK); #1;
    tot++; if (a_ack !== 1'b1) begin bad++; $display("FAIL latch_ack: got %b want 1", a_ack); end
    tot++; if (a_rdata !== 16'hAAAA) begin bad++; $display("FAIL latch_rdata: got %h want aaaa", a_rdata); end
    a_req = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_starvation();
    int n, both, cyc;
    int t_ack [0:15];
    logic [15:0] ports;
    logic [10:0] exp_ports;
    exp_ports = 11'b01110111111;   // bit i = 1 for B, 0 for A
    ports = 16'h0000; n = 0; both = 0; cyc = 0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0010;
    b_req = 1'b1; b_addr = 16'h1234;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK); #1;
      cyc++;
      if (a_ack === 1'b1 && b_ack === 1'b1) both++;
      if (a_ack === 1'b1 || b_ack === 1'b1) begin
        ports[n] = (b_ack === 1'b1);
        t_ack[n] = cyc;
        n++;
        if (n == 3) a_req = 1'b1;
        if (n == 11) break;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tot++; if (n != 11) begin bad++; $display("FAIL starve_grant_count: got %0d want 11", n); end
    for (int i = 0; i < 11; i++) begin
      if (i < n) begin
        tot++; if (ports[i] !== exp_ports[i]) begin bad++; $display("FAIL starve_order[%0d]: got %s want %s", i, ports[i] ? "B" : "A", exp_ports[i] ? "B" : "A"); end
        if (i > 0) begin
          tot++; if (t_ack[i] - t_ack[i-1] != 3) begin bad++; $display("FAIL starve_spacing[%0d]: got %0d want 3", i, t_ack[i] - t_ack[i-1]); end
        end
      end
    end
    tot++; if (both != 0) begin bad++; $display("FAIL acks_coincide: got %0d want 0", both); end
    tot++; if (b_rdata !== 16'hBEEF) begin bad++; $display("FAIL starve_b_rdata: got %h want beef", b_rdata); end
    tot++; if (a_rdata !== 16'hAAAA) begin bad++; $display("FAIL starve_a_rdata: got %h want aaaa", a_rdata); end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid_access();
    int lat, wr, bh, cyc;
    logic [15:0] rd, aa, ad;
    a_access(1'b1, 16'h0300, 16'h0000, lat, wr, rd, aa, ad, bh);
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0300; a_wdata = 16'h1111;
    @(posedge CLK); #1;
    tot++; if (ram_write !== 1'b1) begin bad++; $display("FAIL rst_pre_write: got %b want 1", ram_write); end
    #1 RST_N = 1'b0;
    #1;
    tot++; if (ram_write !== 1'b0) begin bad++; $display("FAIL rst_async_write: got %b want 0", ram_write); end
    tot++; if (ram_address !== 16'h0000) begin bad++; $display("FAIL rst_mid_address: got %h want 0000", ram_address); end
    tot++; if ({a_rdata, b_rdata} !== 32'h0) begin bad++; $display("FAIL rst_mid_rdata: got %h want 00000000", {a_rdata, b_rdata}); end
    @(posedge CLK); #1;
    tot++; if ({a_ack, b_ack} !== 2'b00) begin bad++; $display("FAIL rst_no_ack: got %b want 00", {a_ack, b_ack}); end
    tot++; if (mem[16'h0300] !== 16'h0000) begin bad++; $display("FAIL rst_aborted_write: got %h want 0000", mem[16'h0300]); end
    #2 RST_N = 1'b1;
    cyc = 0; lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      cyc++;
      if (a_ack === 1'b1) begin lat = cyc; break; end
    end
    a_req = 1'b0;
    tot++; if (lat != 2) begin bad++; $display("FAIL rst_rearb_latency: got %0d want 2", lat); end
    tot++; if (mem[16'h0300] !== 16'h1111) begin bad++; $display("FAIL rst_rearb_write: got %h want 1111", mem[16'h0300]); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h00FF; a_wdata = 16'h7E57;
    @(posedge CLK); #1;
    tot++; if (ram_write !== 1'b1) begin bad++; $display("FAIL b2b_write_access: got %b want 1", ram_write); end
    @(posedge CLK); #1;
    tot++; if ({a_ack, ram_write} !== 2'b10) begin bad++; $display("FAIL b2b_turnaround: got ack,wr=%b want 10", {a_ack, ram_write}); end
    a_req = 1'b0; b_req = 1'b1; b_addr = 16'h00FF;
    @(posedge CLK); #1;
    tot++; if (ram_write !== 1'b0) begin bad++; $display("FAIL b2b_idle_write: got %b want 0", ram_write); end
    @(posedge CLK); #1;
    tot++; if ({ram_address, ram_write} !== {16'h00FF, 1'b0}) begin bad++; $display("FAIL b2b_b_access: got %h/%b want 00ff/0", ram_address, ram_write); end
    @(posedge CLK); #1;
    tot++; if ({b_ack, a_ack} !== 2'b10) begin bad++; $display("FAIL b2b_b_ack: got %b want 10", {b_ack, a_ack}); end
    tot++; if (b_rdata !== 16'h7E57) begin bad++; $display("FAIL b2b_b_rdata: got %h want 7e57", b_rdata); end
    b_req = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    tot = 0;
    bad = 0;
    test_reset();
    test_write_read();
    test_addr_latch();
    test_starvation();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", tot, bad);
    $finish;
  end

endmodule
